// File: rtl/fp_exec_stage.sv
// Issue/execute wrapper in front of FP_Unit: decodes one RV32F op, holds the FPU controls for a
// per-class latency, then captures the result and offers it to writeback with valid/ready.
module fp_exec_stage #(
  parameter int unsigned LAT_ADD  = 2,
  parameter int unsigned LAT_MUL  = 3,
  parameter int unsigned LAT_DIV  = 8,
  parameter int unsigned LAT_MISC = 1,
  parameter int unsigned TAG_W    = 5
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_flush,
  input  logic             in_valid,
  output logic             out_ready,
  input  logic [6:0]       in_funct7,
  input  logic [2:0]       in_funct3,
  input  logic [4:0]       in_rs2_field,
  input  logic [31:0]      in_rs1,
  input  logic [31:0]      in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      fpu_rs1,
  output logic [31:0]      fpu_rs2,
  output logic [3:0]       fpu_op,
  output logic [1:0]       fpu_fmt,
  output logic             fpu_addsub,
  output logic [2:0]       fpu_ctrl,
  input  logic [63:0]      fpu_result,
  output logic             out_valid,
  input  logic             in_ready,
  output logic [63:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam int unsigned LAT_AM  = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
  localparam int unsigned LAT_DM  = (LAT_DIV > LAT_MISC) ? LAT_DIV : LAT_MISC;
  localparam int unsigned LAT_MAX = (LAT_AM > LAT_DM) ? LAT_AM : LAT_DM;
  localparam int unsigned CNT_W   = $clog2(LAT_MAX) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [3:0] {
    OP_ADDSUB = 4'd0, OP_MUL = 4'd1, OP_DIV = 4'd2, OP_MINMAX = 4'd3,
    OP_CMP = 4'd4, OP_SGNJ = 4'd5, OP_CVT = 4'd6, OP_NONE = 4'd15
  } fpu_op_t;

  state_t           state, state_next;
  fpu_op_t          op_q, dec_op;
  logic [CNT_W-1:0] cnt, dec_cnt;
  logic             dec_illegal;
  logic             illegal_q;
  logic [TAG_W-1:0] tag_q;
  logic             accept;
  logic             unused_fields;

  assign unused_fields = ^{in_funct3[2], in_rs2_field[4:2]};

  assign out_ready = (state == IDLE) | ((state == DONE) & in_ready);
  assign accept    = in_valid & out_ready & ~in_flush;
  assign fpu_op    = op_q;

  always_comb begin
    dec_op      = OP_NONE;
    dec_cnt     = CNT_W'(LAT_MISC - 1);
    dec_illegal = 1'b0;
    case (in_funct7)
      7'b0000000, 7'b0000100: begin dec_op = OP_ADDSUB; dec_cnt = CNT_W'(LAT_ADD - 1); end
      7'b0001000:             begin dec_op = OP_MUL;    dec_cnt = CNT_W'(LAT_MUL - 1); end
      7'b0001100:             begin dec_op = OP_DIV;    dec_cnt = CNT_W'(LAT_DIV - 1); end
      7'b0010000:             dec_op = OP_SGNJ;
      7'b0010100:             dec_op = OP_MINMAX;
      7'b1010000:             dec_op = OP_CMP;
      7'b1100000:             dec_op = OP_CVT;
      default:                dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (cnt == '0) state_next = DONE;
      DONE: begin
        if (accept)        state_next = BUSY;
        else if (in_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (in_flush) state_next = IDLE;
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) state <= IDLE;
    else           state <= state_next;
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      cnt         <= '0;
      op_q        <= OP_NONE;
      fpu_rs1     <= '0;
      fpu_rs2     <= '0;
      fpu_fmt     <= '0;
      fpu_addsub  <= 1'b0;
      fpu_ctrl    <= '0;
      tag_q       <= '0;
      illegal_q   <= 1'b0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_tag     <= '0;
      out_illegal <= 1'b0;
    end else if (in_flush) begin
      out_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      // Retire first; a same-edge accept (DONE back-to-back) then reloads the controls below.
      if ((state == DONE) && in_ready) out_valid <= 1'b0;
      if (accept) begin
        cnt        <= dec_cnt;
        op_q       <= dec_op;
        fpu_rs1    <= in_rs1;
        fpu_rs2    <= in_rs2;
        fpu_fmt    <= in_rs2_field[1:0];
        fpu_addsub <= (in_funct7 == 7'b0000100);
        fpu_ctrl   <= {1'b0, in_funct3[1:0]};
        tag_q      <= in_tag;
        illegal_q  <= dec_illegal;
      end else if (state == BUSY) begin
        if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          out_result  <= illegal_q ? '0 : fpu_result;
          out_tag     <= tag_q;
          out_illegal <= illegal_q;
          out_valid   <= 1'b1;
        end
      end
    end
  end

endmodule
